// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: valid/ready request port, one-cycle
// write strobe, two-cycle read with registered response.

module sram_ctrl_checker #(
  parameter int ADDR_WIDTH = 7
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  sram_cs,
  input logic                  sram_we,
  input logic                  sram_oe,
  input logic                  rsp_valid,
  input logic [ADDR_WIDTH-1:0] sram_address
);

  // Write-enable and output-enable must never overlap on the SRAM pins.
  a_we_oe_excl: assert property (@(posedge clk) disable iff (!reset) !(sram_we && sram_oe));

  // Strobes are only meaningful while the chip is selected.
  a_strobe_cs: assert property (@(posedge clk) disable iff (!reset) (sram_we || sram_oe) |-> sram_cs);

  // A read response lasts exactly one cycle.
  a_rsp_pulse: assert property (@(posedge clk) disable iff (!reset) rsp_valid |=> !rsp_valid);

  // The address only changes when a new access is launched.
  a_addr_hold: assert property (@(posedge clk) disable iff (!reset)
                                (sram_cs && sram_oe) |=> (sram_address == $past(sram_address)) || !sram_oe);

endmodule

module sram_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  drive_r;
  logic                  handshake_s;

  // Ready is gated by reset so that no request is accepted while reset is held,
  // yet the first edge after release can already complete a handshake.
  assign req_ready   = (state_r == ST_IDLE) && reset;
  assign handshake_s = req_valid && req_ready;

  // The bus is driven from a register that is cleared asynchronously.
  assign sram_data = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};

  // FSM with all SRAM pins and the response registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      wdata_r      <= {DATA_WIDTH{1'b0}};
      drive_r      <= 1'b0;
      sram_cs      <= 1'b0;
      sram_we      <= 1'b0;
      sram_oe      <= 1'b0;
      sram_address <= {ADDR_WIDTH{1'b0}};
      rsp_valid    <= 1'b0;
      rsp_rdata    <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            sram_address <= req_addr;
            wdata_r      <= req_wdata;
            sram_cs      <= 1'b1;
            if (req_we) begin
              state_r <= ST_WRITE;
              sram_we <= 1'b1;
              sram_oe <= 1'b0;
              drive_r <= 1'b1;
            end else begin
              state_r <= ST_READ;
              sram_we <= 1'b0;
              sram_oe <= 1'b1;
              drive_r <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
            sram_oe <= 1'b0;
            drive_r <= 1'b0;
          end
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
          drive_r <= 1'b0;
        end
        ST_READ: begin
          // Second cycle of output-enable gives the SRAM access time to settle.
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_r   <= ST_IDLE;
          rsp_rdata <= sram_data;
          rsp_valid <= 1'b1;
          sram_cs   <= 1'b0;
          sram_we   <= 1'b0;
          sram_oe   <= 1'b0;
          drive_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
          drive_r <= 1'b0;
        end
      endcase
    end
  end

  sram_ctrl_checker #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk          (clk),
    .reset        (reset),
    .sram_cs      (sram_cs),
    .sram_we      (sram_we),
    .sram_oe      (sram_oe),
    .rsp_valid    (rsp_valid),
    .sram_address (sram_address)
  );

endmodule
